// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter_pkg                                         |
// | Description : Shared types for the IF / D memory port arbiter.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mem_port_arbiter_pkg;

  typedef logic [15:0] uword;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  // Width of the ack-wait counter; it only has to reach TIMEOUT_CYC-1.
  function automatic int arb_tmo_w(input int cyc);
    return $clog2(cyc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arb_pick                                                     |
// | Description : Combinational winner select between fetch and data ports.   |
// |               MEM_ARB_RR_EN selects round-robin; otherwise D beats IF.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  arb_owner_e last_owner,
  output arb_owner_e winner
);

`ifdef MEM_ARB_RR_EN
  // On a tie the port that did not win last time takes the grant.
  always_comb begin
    winner = OWN_D;
    if (if_req && d_req) begin
      winner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
    end else if (if_req) begin
      winner = OWN_IF;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = (last_owner == OWN_D);

  // Data access belongs to the older instruction, so it always wins a tie.
  always_comb begin
    winner = OWN_D;
    if (if_req && !d_req) begin
      winner = OWN_IF;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                             |
// | Description : Shares one 16-bit single-ported memory between instruction  |
// |               fetch (IF) and data access (D). One transaction in flight,   |
// |               per-port stall outputs, abort after TIMEOUT_CYC cycles       |
// |               without ack. Optional macro MEM_ARB_RR_EN: round-robin.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic halt_sys,
  input  logic if_req,
  input  uword if_addr,
  output logic if_ready,
  output uword if_rdata,
  input  logic d_req,
  input  logic d_we,
  input  uword d_addr,
  input  uword d_wdata,
  output logic d_ready,
  output uword d_rdata,
  output logic m_req,
  output logic m_we,
  output uword m_addr,
  output uword m_wdata,
  input  uword m_rdata,
  input  logic m_ack,
  output logic stall_if,
  output logic stall_d,
  output logic err_tmo
);

  localparam int                  ARB_TMO_W = arb_tmo_w(TIMEOUT_CYC);
  localparam logic [ARB_TMO_W-1:0] TMO_LAST  = ARB_TMO_W'(TIMEOUT_CYC - 1);

  arb_state_e            state_q;
  arb_owner_e            owner_q;
  logic [ARB_TMO_W-1:0]  tmo_cnt_q;
  logic                  if_ready_q;
  logic                  d_ready_q;
  uword                  if_rdata_q;
  uword                  d_rdata_q;
  logic                  m_req_q;
  logic                  m_we_q;
  uword                  m_addr_q;
  uword                  m_wdata_q;
  logic                  err_tmo_q;
  arb_owner_e            last_owner;
  arb_owner_e            win_owner;
  logic                  owner_req;

`ifdef MEM_ARB_RR_EN
  arb_owner_e last_owner_q;
  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_IF;
`endif

  arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .winner     (win_owner)
  );

  // Whether the current owner is still waiting; a dropped request loses its ready pulse.
  assign owner_req = (owner_q == OWN_D) ? d_req : if_req;

  // Arbiter FSM: grant in IDLE, wait for ack or timeout in GNT_x, ready is high during RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      tmo_cnt_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      err_tmo_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWN_IF;
`endif
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!halt_sys && (if_req || d_req)) begin
            m_req_q   <= 1'b1;
            tmo_cnt_q <= '0;
            owner_q   <= win_owner;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= win_owner;
`endif
            if (win_owner == OWN_D) begin
              m_we_q    <= d_we;
              m_addr_q  <= d_addr;
              m_wdata_q <= d_wdata;
              state_q   <= GNT_D;
            end else begin
              m_we_q    <= 1'b0;
              m_addr_q  <= if_addr;
              m_wdata_q <= '0;
              state_q   <= GNT_IF;
            end
          end
        end
        GNT_IF, GNT_D: begin
          // Ack is tested first so a late ack on the last allowed cycle still counts.
          if (m_ack || (tmo_cnt_q == TMO_LAST)) begin
            m_req_q   <= 1'b0;
            err_tmo_q <= !m_ack;
            state_q   <= RESP;
            if (owner_req) begin
              if (owner_q == OWN_D) begin
                d_ready_q <= 1'b1;
                d_rdata_q <= (m_ack && !m_we_q) ? m_rdata : '0;
              end else begin
                if_ready_q <= 1'b1;
                if_rdata_q <= m_ack ? m_rdata : '0;
              end
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + ARB_TMO_W'(1);
          end
        end
        RESP: begin
          m_we_q    <= 1'b0;
          m_addr_q  <= '0;
          m_wdata_q <= '0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_ready = if_ready_q;
  assign d_ready  = d_ready_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign err_tmo  = err_tmo_q;
  assign stall_if = if_req & ~if_ready_q;
  assign stall_d  = d_req & ~d_ready_q;

endmodule
`default_nettype wire
